mem_lsu: RTL and testbench

Parametrised load/store memory port between the core's memory stage and the DPI-C simulation memory (`pmem_read` / `pmem_write`). It accepts one request at a time over a valid/ready handshake and performs the memory access on the acceptance edge. Load data is byte-lane aligned and sign- or zero-extended. The response is returned after a configurable latency and is held under back-pressure. Misaligned or illegal accesses are flagged as errors and never reach memory.

---
 rtl/mem_lsu.sv | 192 +++++++++++++++++++
 tb/tb_mem_lsu.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// mem_lsu: single-outstanding load/store port between the memory stage and
// the simulation memory reached through pmem_read / pmem_write.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid / req_ready  request handshake (ready only in IDLE, out of reset)
//   req_wen                1 = store, 0 = load
//   req_addr [ADDR_W]      byte address
//   req_wdata [32]         store data, low bits used
//   req_size [3]           funct3 access size
//   resp_valid/resp_ready  response handshake, held under back-pressure
//   resp_rdata [32]        extended load data, 0 for stores and errors
//   resp_err               misaligned access or illegal size
//
// The memory access happens on the acceptance edge; LATENCY counts edges
// from acceptance (inclusive) until resp_valid is seen high.

// Behavioural word memory behind the pmem_read / pmem_write calls.
package mem_lsu_pkg;

  localparam int unsigned LANES = 4;

  logic [31:0] pmem [logic [31:0]];
  int unsigned rd_calls = 0;
  int unsigned wr_calls = 0;

  // Byte-lane mask; the upper strobe nibble folds onto the same 32-bit word.
  function automatic logic [31:0] lane_mask(input logic [7:0] mask);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i] | mask[i+4]) m[8*i +: 8] = 8'hFF;
    end
    return m;
  endfunction

  function automatic logic [31:0] pmem_read(input logic [31:0] addr,
                                            input logic [7:0]  mask);
    logic [31:0] word;
    rd_calls++;
    word = pmem.exists(addr) ? pmem[addr] : 32'h0;
    return word & lane_mask(mask);
  endfunction

  function automatic void pmem_write(input logic [31:0] addr,
                                     input logic [31:0] data,
                                     input logic [7:0]  strb);
    logic [31:0] m;
    logic [31:0] old;
    wr_calls++;
    old = pmem.exists(addr) ? pmem[addr] : 32'h0;
    m   = lane_mask(strb);
    pmem[addr] = (old & ~m) | (data & m);
  endfunction

endpackage

module mem_lsu #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_size,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  import mem_lsu_pkg::*;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;

  logic [31:0] addr32_c;
  logic [31:0] aligned_c;
  logic [1:0]  off_c;
  logic        err_c;
  logic [3:0]  strb_c;
  logic [31:0] wdata_sh_c;

  // Normalise the request address to the 32-bit memory address space.
  if (ADDR_W >= 32) begin : g_addr_trunc
    assign addr32_c = req_addr[31:0];
  end else begin : g_addr_zext
    assign addr32_c = {{(32-ADDR_W){1'b0}}, req_addr};
  end

  assign aligned_c = {addr32_c[31:2], 2'b00};
  assign off_c     = addr32_c[1:0];
  assign req_ready = (state_q == S_IDLE) && rst_n;

  // Illegal size, store with the unsigned bit set, or misaligned half/word.
  always_comb begin
    err_c = 1'b0;
    case (req_size)
      3'b000, 3'b100: err_c = 1'b0;
      3'b001, 3'b101: err_c = off_c[0];
      3'b010:         err_c = (off_c != 2'b00);
      default:        err_c = 1'b1;
    endcase
    if (req_wen && req_size[2]) err_c = 1'b1;
  end

  // Store strobe and data moved onto the addressed byte lanes.
  always_comb begin
    strb_c = 4'b1111;
    case (req_size[1:0])
      2'b00:   strb_c = 4'b0001;
      2'b01:   strb_c = 4'b0011;
      default: strb_c = 4'b1111;
    endcase
    strb_c     = 4'(strb_c << off_c);
    wdata_sh_c = req_wdata << {off_c, 3'b000};
  end

  // Lane-align a read word and sign/zero-extend to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  size);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'h0, sh[7:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  // Request FSM; the payload is captured at acceptance and held until the
  // response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            resp_err   <= err_c;
            resp_rdata <= '0;
            if (!err_c) begin
              if (req_wen) begin
                pmem_write(aligned_c, wdata_sh_c, {4'b0000, strb_c});
              end else begin
                resp_rdata <= load_extend(pmem_read(aligned_c, 8'h0F),
                                          off_c, req_size);
              end
            end
            if (LATENCY <= 1) begin
              state_q    <= S_RESP;
              resp_valid <= 1'b1;
            end else begin
              cnt_q   <= CNT_W'(LATENCY - 1);
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q    <= S_RESP;
            resp_valid <= 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state_q    <= S_IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: three instances (LATENCY 3, 4 and 1) share one
// simulation memory; each step has hand-computed expected values.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_size;
  logic [2:0]  resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata [3];
  logic [2:0]  resp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_lsu #(.LATENCY(3), .ADDR_W(32)) u_l3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]));

  mem_lsu #(.LATENCY(4), .ADDR_W(32)) u_l4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]));

  mem_lsu #(.LATENCY(1), .ADDR_W(32)) u_l1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .resp_valid(resp_valid[2]), .resp_ready(resp_ready), .resp_rdata(resp_rdata[2]),
    .resp_err(resp_err[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    checks++;
    assert (obs === expd) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expd);
    end
  endtask

  // One complete request/response with resp_ready high.
  task automatic txn(input int s, input logic wen, input logic [2:0] size,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input logic exp_err,
                     input int exp_lat, input string tag);
    int unsigned rd0;
    int unsigned wr0;
    int n;
    @(negedge clk);
    req_wen = wen; req_size = size; req_addr = addr; req_wdata = wdata;
    req_valid[s] = 1'b1;
    n = 0;
    while (!req_ready[s] && n < 20) begin @(negedge clk); n++; end
    check($sformatf("%s_ready", tag), 32'(req_ready[s]), 32'd1);
    rd0 = mem_lsu_pkg::rd_calls;
    wr0 = mem_lsu_pkg::wr_calls;
    @(posedge clk); #1;
    req_valid[s] = 1'b0;
    n = 1;
    while (!resp_valid[s] && n < 20) begin @(posedge clk); #1; n++; end
    check($sformatf("%s_latency", tag), 32'(n), 32'(exp_lat));
    check($sformatf("%s_rdata", tag), resp_rdata[s], exp_rd);
    check($sformatf("%s_err", tag), 32'(resp_err[s]), 32'(exp_err));
    check($sformatf("%s_reads", tag), 32'(mem_lsu_pkg::rd_calls - rd0),
          32'(!exp_err && !wen));
    check($sformatf("%s_writes", tag), 32'(mem_lsu_pkg::wr_calls - wr0),
          32'(!exp_err && wen));
    @(posedge clk); #1;
    check($sformatf("%s_done", tag), {29'd0, resp_valid[s], req_ready[s], 1'b0}, 32'h2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned rd0;
    int n;
    bit seen;
    int idx;
    int rsp;
    int last_acc;
    bit acc;
    logic [31:0] s_exp  [4];
    logic [31:0] s_addr [4];
    logic [2:0]  s_size [4];

    rst_n = 1'b0; req_valid = 3'b000; req_wen = 1'b0; req_addr = '0;
    req_wdata = '0; req_size = 3'b010; resp_ready = 1'b1;

    // Reset state
    #12;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_err", 32'(resp_err), 32'h0);
    check("rst_rdata_l3", resp_rdata[0], 32'h0);
    check("rst_rdata_l1", resp_rdata[2], 32'h0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("rel_req_ready", 32'(req_ready), 32'h7);

    // Word round trip, byte and half lanes, errors (LATENCY 3)
    txn(0, 1'b1, 3'b010, 32'h8000_0000, 32'hDEAD_BEEF, 32'h0,         1'b0, 3, "sw_word");
    txn(0, 1'b0, 3'b010, 32'h8000_0000, 32'h0,         32'hDEAD_BEEF, 1'b0, 3, "lw_word");
    txn(0, 1'b1, 3'b000, 32'h8000_0003, 32'h0000_0080, 32'h0,         1'b0, 3, "sb_lane3");
    txn(0, 1'b0, 3'b000, 32'h8000_0003, 32'h0,         32'hFFFF_FF80, 1'b0, 3, "lb_lane3");
    txn(0, 1'b0, 3'b100, 32'h8000_0003, 32'h0,         32'h0000_0080, 1'b0, 3, "lbu_lane3");
    txn(0, 1'b0, 3'b010, 32'h8000_0000, 32'h0,         32'h80AD_BEEF, 1'b0, 3, "lw_merged");
    txn(0, 1'b0, 3'b001, 32'h8000_0002, 32'h0,         32'hFFFF_80AD, 1'b0, 3, "lh_upper");
    txn(0, 1'b0, 3'b101, 32'h8000_0002, 32'h0,         32'h0000_80AD, 1'b0, 3, "lhu_upper");
    txn(0, 1'b1, 3'b001, 32'h8000_0004, 32'h0000_CAFE, 32'h0,         1'b0, 3, "sh_low");
    txn(0, 1'b1, 3'b001, 32'h8000_0006, 32'hFFFF_1234, 32'h0,         1'b0, 3, "sh_high");
    txn(0, 1'b0, 3'b010, 32'h8000_0004, 32'h0,         32'h1234_CAFE, 1'b0, 3, "lw_halves");
    txn(0, 1'b0, 3'b001, 32'h8000_0001, 32'h0,         32'h0,         1'b1, 3, "lh_misalign");
    txn(0, 1'b1, 3'b010, 32'h8000_0002, 32'h1234_5678, 32'h0,         1'b1, 3, "sw_misalign");
    txn(0, 1'b0, 3'b010, 32'h8000_0000, 32'h0,         32'h80AD_BEEF, 1'b0, 3, "lw_after_err");
    txn(0, 1'b0, 3'b011, 32'h8000_0000, 32'h0,         32'h0,         1'b1, 3, "size_011");
    txn(0, 1'b1, 3'b100, 32'h8000_0000, 32'h0000_0055, 32'h0,         1'b1, 3, "store_unsigned");
    txn(0, 1'b0, 3'b010, 32'h8000_0000, 32'h0,         32'h80AD_BEEF, 1'b0, 3, "lw_final");

    // Back-pressure with a second request held behind the first
    @(negedge clk);
    resp_ready = 1'b0; req_wen = 1'b0; req_size = 3'b010; req_addr = 32'h8000_0000;
    req_valid[0] = 1'b1;
    rd0 = mem_lsu_pkg::rd_calls;
    @(posedge clk); #1;
    req_size = 3'b100; req_addr = 32'h8000_0003;
    n = 1;
    while (!resp_valid[0] && n < 20) begin @(posedge clk); #1; n++; end
    check("bp_latency", 32'(n), 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp_rdata_c%0d", i), resp_rdata[0], 32'h80AD_BEEF);
      check($sformatf("bp_flags_c%0d", i),
            {29'd0, resp_valid[0], req_ready[0], resp_err[0]}, 32'h4);
    end
    check("bp_reads_held", 32'(mem_lsu_pkg::rd_calls - rd0), 32'd1);
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_handshake", {29'd0, resp_valid[0], req_ready[0], 1'b0}, 32'h2);
    @(posedge clk); #1;
    check("bp_next_accept", 32'(req_ready[0]), 32'd0);
    check("bp_reads_next", 32'(mem_lsu_pkg::rd_calls - rd0), 32'd2);
    req_valid[0] = 1'b0;
    n = 1;
    while (!resp_valid[0] && n < 20) begin @(posedge clk); #1; n++; end
    check("bp_next_rdata", resp_rdata[0], 32'h0000_0080);
    @(posedge clk); #1;

    // Reset while waiting (LATENCY 4)
    @(negedge clk);
    req_wen = 1'b0; req_size = 3'b010; req_addr = 32'h8000_0000; req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rw_pre_valid", 32'(resp_valid[1]), 32'd0);
    rst_n = 1'b0; #1;
    check("rw_valid_drop", 32'(resp_valid), 32'h0);
    check("rw_ready_drop", 32'(req_ready), 32'h0);
    check("rw_rdata_drop", resp_rdata[1], 32'h0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (resp_valid[1]) seen = 1'b1;
    end
    check("rw_no_resp", 32'(seen), 32'd0);
    txn(1, 1'b0, 3'b010, 32'h8000_0000, 32'h0, 32'h80AD_BEEF, 1'b0, 4, "rw_lw_after");

    // Minimum-latency streaming (LATENCY 1)
    s_exp  = '{32'h80AD_BEEF, 32'hFFFF_FF80, 32'h0000_80AD, 32'h0000_00EF};
    s_addr = '{32'h8000_0000, 32'h8000_0003, 32'h8000_0002, 32'h8000_0000};
    s_size = '{3'b010, 3'b000, 3'b101, 3'b100};
    idx = 0; rsp = 0; last_acc = -1;
    @(negedge clk);
    req_wen = 1'b0; req_addr = s_addr[0]; req_size = s_size[0]; req_valid[2] = 1'b1;
    for (int cyc = 0; cyc < 40 && rsp < 4; cyc++) begin
      acc = req_valid[2] && req_ready[2];
      if (resp_valid[2]) begin
        check($sformatf("stream_rdata_%0d", rsp), resp_rdata[2], s_exp[rsp]);
        rsp++;
      end
      if (acc) begin
        if (last_acc >= 0) check($sformatf("stream_gap_%0d", idx), 32'(cyc - last_acc), 32'd2);
        last_acc = cyc;
      end
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 4) begin
          req_addr = s_addr[idx]; req_size = s_size[idx];
        end else begin
          req_valid[2] = 1'b0;
        end
      end
      @(negedge clk);
    end
    check("stream_resp_count", 32'(rsp), 32'd4);
    check("stream_accepts", 32'(idx), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
